// File: rtl/llr_scaler.sv
// llr_scaler: scales a stream of signed LLR samples by an unsigned Q(SW-8).8 factor.
// The product is rounded to nearest and saturated symmetrically to +/-(2^(DW-1)-1).
// The pipeline has two register stages:
//   stage 1 holds the full product.
//   stage 2 holds the rounded, saturated sample and drives m_*.
// A new scale loaded mid-frame is parked until the frame's last beat is accepted.
// This keeps the scale constant across a frame.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   scale_in          - scale factor (256 = 1.0)
//   scale_load        - one-cycle strobe capturing scale_in
//   s_valid/s_ready   - input stream handshake
//   s_data/s_last     - input stream payload
//   m_valid/m_ready   - output stream handshake
//   m_data/m_last     - output stream payload
//   sat_cnt           - saturated beats in the current frame
//
// Optional feature: define LLR_SCALER_STAT_EN to build the saturation counter.
// Without it, sat_cnt is tied to 0.
module llr_scaler #(
    parameter int unsigned DW = 8,
    parameter int unsigned SW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW-1:0]        scale_in,
    input  logic                 scale_load,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_data,
    output logic                 m_last,
    output logic [15:0]          sat_cnt
);

    localparam int unsigned PW = DW + SW + 1;
    localparam logic signed [PW-1:0] SatHi  = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] SatLo  = -SatHi;
    localparam logic signed [PW-1:0] RndOff = PW'(128);
    localparam logic [SW-1:0]        ScaleOne = SW'(256);

    typedef enum logic [0:0] {StIdle, StFrame} state_e;

    state_e              state_q;
    logic [SW-1:0]       scale_q;
    logic [SW-1:0]       pend_q;
    logic                pend_valid_q;

    logic                s1_valid_q;
    logic signed [PW-1:0] s1_prod_q;
    logic                s1_last_q;

    logic                accept;
    logic                adv;
    logic signed [PW-1:0] data_ext;
    logic signed [PW-1:0] scale_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic                sat_hi;
    logic                sat_lo;
    logic signed [DW-1:0] s2_data_d;

    // Stage 2 moves when it is empty or being drained.
    assign adv     = !m_valid || m_ready;
    assign s_ready = !s1_valid_q || adv;
    assign accept  = s_valid && s_ready;

    // The scale is zero-extended so it always multiplies as a positive value.
    assign data_ext  = {{(SW + 1){s_data[DW-1]}}, s_data};
    assign scale_ext = {{DW{1'b0}}, 1'b0, scale_q};
    assign prod      = data_ext * scale_ext;

    always_comb begin
        rnd    = (s1_prod_q + RndOff) >>> 8;
        sat_hi = rnd > SatHi;
        sat_lo = rnd < SatLo;
        if (sat_hi) begin
            s2_data_d = SatHi[DW-1:0];
        end else if (sat_lo) begin
            s2_data_d = SatLo[DW-1:0];
        end else begin
            s2_data_d = rnd[DW-1:0];
        end
    end

    // Frame tracking and scale control; the beat accepted this edge still uses scale_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            scale_q      <= ScaleOne;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else if (accept && s_last) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            if (scale_load) begin
                scale_q <= scale_in;
            end else if (pend_valid_q) begin
                scale_q <= pend_q;
            end
        end else begin
            if (scale_load) begin
                if (state_q == StIdle) begin
                    scale_q <= scale_in;
                end else begin
                    pend_q       <= scale_in;
                    pend_valid_q <= 1'b1;
                end
            end
            if (accept) begin
                state_q <= StFrame;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_last_q  <= 1'b0;
        end else if (s_ready) begin
            s1_valid_q <= s_valid;
            if (s_valid) begin
                s1_prod_q <= prod;
                s1_last_q <= s_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (adv) begin
            m_valid <= s1_valid_q;
            if (s1_valid_q) begin
                m_data <= s2_data_d;
                m_last <= s1_last_q;
            end
        end
    end

`ifdef LLR_SCALER_STAT_EN
    logic        s1_first_q;
    logic        sat;
    logic [15:0] sat_cnt_q;

    assign sat = sat_hi || sat_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_first_q <= 1'b0;
        end else if (accept) begin
            s1_first_q <= (state_q == StIdle);
        end
    end

    // The first beat of a frame restarts the count, including itself if saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (adv && s1_valid_q) begin
            if (s1_first_q) begin
                sat_cnt_q <= {15'd0, sat};
            end else if (sat && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_q <= sat_cnt_q + 16'd1;
            end
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_llr_scaler.sv
module tb_llr_scaler;

    localparam int DW = 8;
    localparam int SW = 12;

    typedef logic [DW:0] beat_t; // {last, data}

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [SW-1:0]        scale_in = '0;
    logic                 scale_load = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_last = 1'b0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic signed [DW-1:0] m_data;
    logic                 m_last;
    logic [15:0]          sat_cnt;

    int    tests = 0;
    int    fails = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t want[$];

    // Reference state: the frame/scale rules applied at each accepting edge
    int md_active = 256;
    int md_pend = 0;
    bit md_pend_v = 0;
    bit md_frame = 0;
    int md_sat = 0;
    bit acc_last = 0;
    int mon_r;
    bit mon_sat;

    llr_scaler #(.DW(DW), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .scale_in   (scale_in),
        .scale_load (scale_load),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Rounded (half up) scaled value, clamped symmetrically
    function automatic int ref_scale(input int d, input int s, output bit sat);
        int p;
        int r;
        p = d * s + 128;
        if (p >= 0) r = p / 256;
        else r = -((-p + 255) / 256);
        sat = 1'b0;
        if (r > 127) begin r = 127; sat = 1'b1; end
        else if (r < -127) begin r = -127; sat = 1'b1; end
        return r;
    endfunction

    function automatic beat_t mk(input bit l, input int d);
        return {l, d[DW-1:0]};
    endfunction

    // Sampled at negedge: inputs and outputs are settled for the coming rising edge
    always @(negedge clk) begin
        acc_last = s_valid && s_ready && !rst;
        if (rst) begin
            exp_q.delete();
            got_q.delete();
            md_active = 256;
            md_pend_v = 0;
            md_frame  = 0;
            md_sat    = 0;
        end else begin
            if (m_valid && m_ready) got_q.push_back({m_last, m_data});
            if (s_valid && s_ready) begin
                mon_r = ref_scale(int'(s_data), md_active, mon_sat);
                if (!md_frame) md_sat = 0;
                if (mon_sat && md_sat < 65535) md_sat++;
                exp_q.push_back({s_last, mon_r[DW-1:0]});
            end
            if (s_valid && s_ready && s_last) begin
                if (scale_load) md_active = int'(scale_in);
                else if (md_pend_v) md_active = md_pend;
                md_pend_v = 0;
                md_frame  = 0;
            end else begin
                if (scale_load) begin
                    if (md_frame) begin md_pend = int'(scale_in); md_pend_v = 1; end
                    else md_active = int'(scale_in);
                end
                if (s_valid && s_ready) md_frame = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        scale_load = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_beat(input int d, input bit l);
        s_data  = d[DW-1:0];
        s_last  = l;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc_last) begin
                s_valid = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL send_beat: beat %0d not accepted within 200 cycles", d);
        s_valid = 1'b0;
    endtask

    task automatic load_scale(input int v);
        scale_in   = v[SW-1:0];
        scale_load = 1'b1;
        tick();
        scale_load = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 1000 && got_q.size() < n; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        s_valid = 1'b1;
        s_data  = 8'sd55;
        do_reset();
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        tests++; if (m_data !== 8'sd0) begin fails++; $display("FAIL reset_m_data got %0d want 0", m_data); end
        tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_m_last got %b want 0", m_last); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        tests++; if (sat_cnt !== 16'd0) begin fails++; $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt); end
    endtask

    task automatic test_latency();
        do_reset();
        s_data = 8'sd100; s_last = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tests++; if (acc_last !== 1'b1) begin fails++; $display("FAIL lat_accept got %b want 1", acc_last); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL lat_cycle1_valid got %b want 0", m_valid); end
        tick();
        tests++;
        if (m_valid !== 1'b1 || m_data !== 8'sd100 || m_last !== 1'b1) begin
            fails++;
            $display("FAIL lat_cycle2 got v=%b d=%0d l=%b want v=1 d=100 l=1", m_valid, m_data, m_last);
        end
        tick();
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL lat_cycle3_valid got %b want 0", m_valid); end
    endtask

    task automatic test_scales();
        do_reset();
        want.delete();
        load_scale(362);
        send_beat(50, 0); send_beat(-50, 0); send_beat(100, 1);
        load_scale(0);
        send_beat(127, 0); send_beat(-128, 1);
        load_scale(4095);
        send_beat(1, 1);
        want.push_back(mk(0, 71)); want.push_back(mk(0, -71)); want.push_back(mk(1, 127));
        want.push_back(mk(0, 0));  want.push_back(mk(1, 0));   want.push_back(mk(1, 16));
        wait_drain(6);
        tests++; if (got_q.size() != 6) begin fails++; $display("FAIL scales_count got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== want[i]) begin fails++; $display("FAIL scales_beat%0d got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_backpressure();
        int vals[4] = '{10, 20, 30, 40};
        int k = 0;
        do_reset();
        want.delete();
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            s_data = vals[k][DW-1:0];
            s_last = (k == 3);
            tick();
            if (acc_last) k++;
            if (c >= 2) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== 8'sd10 || m_last !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_hold_c%0d got v=%b d=%0d want v=1 d=10", c, m_valid, m_data);
                end
            end
        end
        tests++; if (k != 2) begin fails++; $display("FAIL bp_accepted got %0d want 2", k); end
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready got %b want 0", s_ready); end
        m_ready = 1'b1;
        for (int c = 0; c < 50 && k < 4; c++) begin
            s_data = vals[k][DW-1:0];
            s_last = (k == 3);
            tick();
            if (acc_last) k++;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) want.push_back(mk(i == 3, vals[i]));
        wait_drain(4);
        tests++; if (got_q.size() != 4) begin fails++; $display("FAIL bp_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== want[i]) begin fails++; $display("FAIL bp_beat%0d got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_pending();
        do_reset();
        want.delete();
        send_beat(40, 0); send_beat(40, 0);
        load_scale(512);
        send_beat(40, 0); send_beat(40, 1);
        for (int i = 0; i < 4; i++) send_beat(40, i == 3);
        for (int i = 0; i < 8; i++) want.push_back(mk((i % 4) == 3, (i < 4) ? 40 : 80));
        wait_drain(8);
        tests++; if (got_q.size() != 8) begin fails++; $display("FAIL pend_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== want[i]) begin fails++; $display("FAIL pend_beat%0d got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_stat();
        int want_cnt;
        do_reset();
        send_beat(-128, 0); send_beat(127, 0); send_beat(-128, 1);
        wait_drain(3);
        tests++;
        if (got_q.size() != 3 || got_q[0] !== mk(0, -127) || got_q[1] !== mk(0, 127) || got_q[2] !== mk(1, -127)) begin
            fails++;
            $display("FAIL stat_outputs got %0d beats, first %h want 3 beats -127,127,-127", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : beat_t'(0));
        end
`ifdef LLR_SCALER_STAT_EN
        want_cnt = 2;
`else
        want_cnt = 0;
`endif
        tests++; if (sat_cnt !== want_cnt[15:0]) begin fails++; $display("FAIL stat_frame_cnt got %0d want %0d", sat_cnt, want_cnt); end
        send_beat(0, 0);
        wait_drain(4);
        tests++; if (sat_cnt !== 16'd0) begin fails++; $display("FAIL stat_new_frame_cnt got %0d want 0", sat_cnt); end
        send_beat(0, 1);
        wait_drain(5);
    endtask

    task automatic test_reset_midframe();
        do_reset();
        m_ready = 1'b0;
        send_beat(5, 0); send_beat(6, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_m_valid got %b want 0", m_valid); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rstmid_s_ready got %b want 1", s_ready); end
        m_ready = 1'b1;
        load_scale(512);
        send_beat(40, 1);
        wait_drain(1);
        tests++;
        if (got_q.size() != 1 || got_q[0] !== mk(1, 80)) begin
            fails++;
            $display("FAIL rstmid_frame got %0d beats, first %h want 1 beat %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : beat_t'(0), mk(1, 80));
        end
    endtask

    task automatic test_random();
        int n = 400;
        int sent = 0;
        int want_cnt;
        do_reset();
        for (int cyc = 0; cyc < 8000 && sent < n; cyc++) begin
            if (!s_valid && $urandom_range(0, 9) < 7) begin
                s_valid = 1'b1;
                s_data  = DW'($urandom);
                s_last  = ($urandom_range(0, 3) == 0);
            end
            scale_load = ($urandom_range(0, 6) == 0);
            scale_in   = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, 4095))
                                                     : SW'($urandom_range(128, 512));
            m_ready    = ($urandom_range(0, 3) != 0);
            tick();
            if (s_valid && acc_last) begin
                sent++;
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        scale_load = 1'b0;
        m_ready = 1'b1;
        wait_drain(n);
        tests++;
        if (got_q.size() != n || exp_q.size() != n) begin
            fails++;
            $display("FAIL rand_count got %0d model %0d want %0d", got_q.size(), exp_q.size(), n);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
`ifdef LLR_SCALER_STAT_EN
        want_cnt = md_sat;
`else
        want_cnt = 0;
`endif
        tests++; if (sat_cnt !== want_cnt[15:0]) begin fails++; $display("FAIL rand_sat_cnt got %0d want %0d", sat_cnt, want_cnt); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scales();
        test_backpressure();
        test_pending();
        test_stat();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
